// File: rtl/motor_commutation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : motor_commutation_ctrl
// Purpose  : BLDC startup and commutation sequencer. Walks the motor from
//            standstill through rotor alignment and an open-loop forced
//            commutation ramp. Hands over to encoder-driven commutation once
//            the measured speed is high enough, and latches a stall fault.
// Ports    : i_clk/i_rst           - clock, synchronous active-high reset
//            i_enable/i_brake      - level run and brake requests
//            i_enc_step            - encoder step pulse (stall watchdog kick)
//            i_speed/i_speed_valid - measured speed and its qualifier
//            i_fault_clear         - fault acknowledge (needs i_enable=0)
//            i_param_*             - alignment, ramp, threshold, stall settings
//            o_force_step_trigger/o_force_step_value - forced step to pattern gen
//            o_bypass_power        - 1 except in RUN
//            o_brake               - 1 in BRAKE and FAULT
//            o_state               - IDLE=0 ALIGN=1 RAMP=2 RUN=3 BRAKE=4 FAULT=5
//            o_fault               - latched stall fault
// Revision : 1.0 - initial release
// ============================================================================
module motor_commutation_ctrl #(
    parameter int K_SPDWIDTH = 15,
    parameter int K_TMRWIDTH = 16,
    parameter int K_NSTEPS   = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_brake,
    input  logic                  i_enc_step,
    input  logic [K_SPDWIDTH-1:0] i_speed,
    input  logic                  i_speed_valid,
    input  logic                  i_fault_clear,
    input  logic [K_TMRWIDTH-1:0] i_param_align_time,
    input  logic [K_TMRWIDTH-1:0] i_param_ramp_start,
    input  logic [K_TMRWIDTH-1:0] i_param_ramp_min,
    input  logic [K_TMRWIDTH-1:0] i_param_ramp_dec,
    input  logic [K_SPDWIDTH-1:0] i_param_spd_thr_hi,
    input  logic [K_SPDWIDTH-1:0] i_param_spd_thr_lo,
    input  logic [K_TMRWIDTH-1:0] i_param_stall_time,
    output logic                  o_force_step_trigger,
    output logic [2:0]            o_force_step_value,
    output logic                  o_bypass_power,
    output logic                  o_brake,
    output logic [2:0]            o_state,
    output logic                  o_fault
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ALIGN = 3'd1;
    localparam logic [2:0] c_S_RAMP  = 3'd2;
    localparam logic [2:0] c_S_RUN   = 3'd3;
    localparam logic [2:0] c_S_BRAKE = 3'd4;
    localparam logic [2:0] c_S_FAULT = 3'd5;

    localparam logic [2:0]            c_LAST_IDX = 3'(K_NSTEPS - 1);
    localparam logic [K_TMRWIDTH-1:0] c_TMR_ZERO = '0;
    localparam logic [K_TMRWIDTH-1:0] c_TMR_ONE  = {{(K_TMRWIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [K_TMRWIDTH-1:0] r_timer;
    logic [K_TMRWIDTH-1:0] r_period;
    logic [2:0]            r_step_idx;
    logic                  r_trig;
    logic [2:0]            r_val;
    logic                  r_bypass;
    logic                  r_brake;
    logic                  r_fault;

    logic [2:0]            w_nxt_state;
    logic [K_TMRWIDTH-1:0] w_nxt_timer;
    logic [K_TMRWIDTH-1:0] w_nxt_period;
    logic [2:0]            w_nxt_idx;
    logic                  w_nxt_trig;
    logic [2:0]            w_nxt_val;

    logic [K_TMRWIDTH-1:0] w_timer_inc;
    logic [K_TMRWIDTH-1:0] w_period_eff;
    logic                  w_ramp_expire;
    logic [K_TMRWIDTH-1:0] w_period_dec;
    logic [2:0]            w_idx_next;

    // Timer saturates at all-ones so long waits never alias to short ones.
    assign w_timer_inc   = (&r_timer) ? r_timer : r_timer + c_TMR_ONE;
    // A zero period behaves as one cycle per step.
    assign w_period_eff  = (r_period == c_TMR_ZERO) ? c_TMR_ONE : r_period;
    assign w_ramp_expire = (r_timer >= (w_period_eff - c_TMR_ONE));
    // Shrink the step period, never below the floor (also covers underflow).
    assign w_period_dec  = ((r_period < i_param_ramp_dec) ||
                            ((r_period - i_param_ramp_dec) < i_param_ramp_min))
                           ? i_param_ramp_min : (r_period - i_param_ramp_dec);
    assign w_idx_next    = (r_step_idx >= c_LAST_IDX) ? 3'd0 : r_step_idx + 3'd1;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_timer  = r_timer;
        w_nxt_period = r_period;
        w_nxt_idx    = r_step_idx;
        w_nxt_trig   = 1'b0;
        w_nxt_val    = r_val;
        if (r_state == c_S_FAULT) begin
            // Fault is sticky: only an acknowledge with the run request
            // dropped releases it.
            if (i_fault_clear && !i_enable) begin
                w_nxt_state = c_S_IDLE;
                w_nxt_timer = c_TMR_ZERO;
            end
        end else if (i_brake) begin
            w_nxt_state = c_S_BRAKE;
            w_nxt_timer = c_TMR_ZERO;
        end else if (!i_enable && ((r_state == c_S_ALIGN) || (r_state == c_S_RAMP) ||
                                   (r_state == c_S_RUN))) begin
            w_nxt_state = c_S_IDLE;
            w_nxt_timer = c_TMR_ZERO;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (i_enable) begin
                        // Kick the pattern generator to step 0 for alignment.
                        w_nxt_state = c_S_ALIGN;
                        w_nxt_idx   = 3'd0;
                        w_nxt_timer = c_TMR_ZERO;
                        w_nxt_trig  = 1'b1;
                        w_nxt_val   = 3'd0;
                    end
                end
                c_S_ALIGN: begin
                    if (r_timer == i_param_align_time) begin
                        w_nxt_state  = c_S_RAMP;
                        w_nxt_period = i_param_ramp_start;
                        w_nxt_timer  = c_TMR_ZERO;
                    end else begin
                        w_nxt_timer = w_timer_inc;
                    end
                end
                c_S_RAMP: begin
                    // Handover beats a coincident step expiry: no pulse issued.
                    if (i_speed_valid && (i_speed >= i_param_spd_thr_hi)) begin
                        w_nxt_state = c_S_RUN;
                        w_nxt_timer = c_TMR_ZERO;
                    end else if (w_ramp_expire) begin
                        w_nxt_idx    = w_idx_next;
                        w_nxt_val    = w_idx_next;
                        w_nxt_trig   = 1'b1;
                        w_nxt_timer  = c_TMR_ZERO;
                        w_nxt_period = w_period_dec;
                    end else begin
                        w_nxt_timer = w_timer_inc;
                    end
                end
                c_S_RUN: begin
                    // Stall check first so it wins over a low-speed fallback.
                    if ((i_param_stall_time != c_TMR_ZERO) &&
                        (r_timer >= i_param_stall_time)) begin
                        w_nxt_state = c_S_FAULT;
                    end else if (i_speed_valid && (i_speed < i_param_spd_thr_lo)) begin
                        w_nxt_state  = c_S_RAMP;
                        w_nxt_period = i_param_ramp_start;
                        w_nxt_timer  = c_TMR_ZERO;
                    end else begin
                        w_nxt_timer = i_enc_step ? c_TMR_ZERO : w_timer_inc;
                    end
                end
                c_S_BRAKE: begin
                    // Reached only with i_brake low; always pass through IDLE.
                    w_nxt_state = c_S_IDLE;
                    w_nxt_timer = c_TMR_ZERO;
                end
                default: begin
                    w_nxt_state = c_S_IDLE;
                    w_nxt_timer = c_TMR_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= c_S_IDLE;
            r_timer    <= c_TMR_ZERO;
            r_period   <= c_TMR_ZERO;
            r_step_idx <= 3'd0;
            r_trig     <= 1'b0;
            r_val      <= 3'd0;
            r_bypass   <= 1'b1;
            r_brake    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_timer    <= w_nxt_timer;
            r_period   <= w_nxt_period;
            r_step_idx <= w_nxt_idx;
            r_trig     <= w_nxt_trig;
            r_val      <= w_nxt_val;
            // Level outputs follow the state being entered on this edge.
            r_bypass   <= (w_nxt_state != c_S_RUN);
            r_brake    <= (w_nxt_state == c_S_BRAKE) || (w_nxt_state == c_S_FAULT);
            r_fault    <= (w_nxt_state == c_S_FAULT);
        end
    end

    assign o_force_step_trigger = r_trig;
    assign o_force_step_value   = r_val;
    assign o_bypass_power       = r_bypass;
    assign o_brake              = r_brake;
    assign o_state              = r_state;
    assign o_fault              = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_motor_commutation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_commutation_ctrl
// Purpose  : Self-checking bench for motor_commutation_ctrl. Table rows hold
//            inputs for a number of cycles with the outputs expected after
//            every edge; hand-written sequences cover ramp pulse spacing and
//            reset while a forced-step pulse is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_commutation_ctrl;

    localparam int K_SPDWIDTH = 15;
    localparam int K_TMRWIDTH = 16;
    localparam int K_NSTEPS   = 6;

    logic                  clk;
    logic                  rst;
    logic                  r_enable;
    logic                  r_brake_in;
    logic                  r_enc_step;
    logic [K_SPDWIDTH-1:0] r_speed;
    logic                  r_speed_valid;
    logic                  r_fault_clear;
    logic [K_TMRWIDTH-1:0] r_align_time;
    logic [K_TMRWIDTH-1:0] r_ramp_start;
    logic [K_TMRWIDTH-1:0] r_ramp_min;
    logic [K_TMRWIDTH-1:0] r_ramp_dec;
    logic [K_SPDWIDTH-1:0] r_thr_hi;
    logic [K_SPDWIDTH-1:0] r_thr_lo;
    logic [K_TMRWIDTH-1:0] r_stall_time;

    logic                  w_trig;
    logic [2:0]            w_val;
    logic                  w_bypass;
    logic                  w_brake;
    logic [2:0]            w_state;
    logic                  w_fault;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       trig;
        logic [2:0] val;
        logic       byp;
        logic       brk;
        logic       flt;
    } out_t;

    typedef struct {
        logic        en;
        logic        brk;
        logic        sv;
        logic [14:0] spd;
        logic        enc;
        logic        fclr;
        int          n;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];

    motor_commutation_ctrl #(
        .K_SPDWIDTH(K_SPDWIDTH),
        .K_TMRWIDTH(K_TMRWIDTH),
        .K_NSTEPS  (K_NSTEPS)
    ) u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_enable            (r_enable),
        .i_brake             (r_brake_in),
        .i_enc_step          (r_enc_step),
        .i_speed             (r_speed),
        .i_speed_valid       (r_speed_valid),
        .i_fault_clear       (r_fault_clear),
        .i_param_align_time  (r_align_time),
        .i_param_ramp_start  (r_ramp_start),
        .i_param_ramp_min    (r_ramp_min),
        .i_param_ramp_dec    (r_ramp_dec),
        .i_param_spd_thr_hi  (r_thr_hi),
        .i_param_spd_thr_lo  (r_thr_lo),
        .i_param_stall_time  (r_stall_time),
        .o_force_step_trigger(w_trig),
        .o_force_step_value  (w_val),
        .o_bypass_power      (w_bypass),
        .o_brake             (w_brake),
        .o_state             (w_state),
        .o_fault             (w_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic [2:0] st, input logic trig, input logic [2:0] val,
                                input logic byp, input logic brk, input logic flt);
        out_t o;
        o.st = st; o.trig = trig; o.val = val; o.byp = byp; o.brk = brk; o.flt = flt;
        return o;
    endfunction

    function automatic vec_t row(input logic en, input logic brk, input logic sv,
                                 input int spd, input logic enc, input logic fclr,
                                 input int n, input out_t exp);
        vec_t v;
        v.en = en; v.brk = brk; v.sv = sv; v.spd = 15'(spd); v.enc = enc; v.fclr = fclr;
        v.n = n; v.exp = exp;
        return v;
    endfunction

    // Pop the oldest expectation and compare against the DUT outputs now.
    task automatic sb_check(input string name);
        out_t act;
        out_t exp;
        act = {w_state, w_trig, w_val, w_bypass, w_brake, w_fault};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: got st=%0d trig=%0b val=%0d byp=%0b brk=%0b flt=%0b, want st=%0d trig=%0b val=%0d byp=%0b brk=%0b flt=%0b",
                         name, act.st, act.trig, act.val, act.byp, act.brk, act.flt,
                         exp.st, exp.trig, exp.val, exp.byp, exp.brk, exp.flt);
            end
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                r_enable      = tbl[r].en;
                r_brake_in    = tbl[r].brk;
                r_speed_valid = tbl[r].sv;
                r_speed       = tbl[r].spd;
                r_enc_step    = tbl[r].enc;
                r_fault_clear = tbl[r].fclr;
                sb.push_back(tbl[r].exp);
                @(posedge clk);
                @(negedge clk);
                sb_check($sformatf("row%0d.cyc%0d", r, c));
            end
        end
        r_speed_valid = 1'b0;
        r_enc_step    = 1'b0;
        r_fault_clear = 1'b0;
    endtask

    // Hold enable in RAMP and expect the next forced pulse after exp_int edges.
    task automatic wait_pulse(input int exp_int, input logic [2:0] exp_val, input string name);
        int cnt;
        cnt = 0;
        r_enable = 1'b1; r_brake_in = 1'b0; r_speed_valid = 1'b0; r_enc_step = 1'b0;
        r_fault_clear = 1'b0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end while (!w_trig && cnt < 30);
        checks++;
        if (!w_trig || cnt != exp_int || w_val !== exp_val || w_state !== 3'd2) begin
            errors++;
            $display("FAIL %s: got trig=%0b interval=%0d val=%0d st=%0d, want trig=1 interval=%0d val=%0d st=2",
                     name, w_trig, cnt, w_val, w_state, exp_int, exp_val);
        end
    endtask

    localparam logic [2:0] IDLE = 3'd0, ALIGN = 3'd1, RAMP = 3'd2, RUN = 3'd3,
                           BRK = 3'd4, FLT = 3'd5;

    initial begin
        int ints[7];
        logic [2:0] vals[7];
        ints = '{10, 7, 4, 4, 4, 4, 4};
        vals = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};

        // en brk sv spd enc fclr n  {st trig val byp brk flt}
        // 0..2: startup to RAMP
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(ALIGN,1,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 4, mk(ALIGN,0,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(RAMP ,0,0,1,0,0)));
        // 3..4: handover at threshold and fallback below lo
        tbl.push_back(row(1,0,1,200,0,0, 1, mk(RUN  ,0,1,0,0,0)));
        tbl.push_back(row(1,0,1, 99,0,0, 1, mk(RAMP ,0,1,1,0,0)));
        // 5..13: RUN, encoder kick, stall, fault hold and release
        tbl.push_back(row(1,0,1,250,0,0, 1, mk(RUN  ,0,2,0,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0,40, mk(RUN  ,0,2,0,0,0)));
        tbl.push_back(row(1,0,0,  0,1,0, 1, mk(RUN  ,0,2,0,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0,50, mk(RUN  ,0,2,0,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(FLT  ,0,2,1,1,1)));
        tbl.push_back(row(1,0,0,  0,0,1, 2, mk(FLT  ,0,2,1,1,1)));
        tbl.push_back(row(0,1,0,  0,0,0, 2, mk(FLT  ,0,2,1,1,1)));
        tbl.push_back(row(0,0,0,  0,0,1, 1, mk(IDLE ,0,2,1,0,0)));
        tbl.push_back(row(0,0,0,  0,0,0, 2, mk(IDLE ,0,2,1,0,0)));
        // 14..23: brake from RAMP, release via IDLE, disable from RAMP
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(ALIGN,1,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 4, mk(ALIGN,0,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(RAMP ,0,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 3, mk(RAMP ,0,0,1,0,0)));
        tbl.push_back(row(1,1,0,  0,0,0,12, mk(BRK  ,0,0,1,1,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(IDLE ,0,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(ALIGN,1,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 4, mk(ALIGN,0,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(RAMP ,0,0,1,0,0)));
        tbl.push_back(row(0,0,0,  0,0,0, 1, mk(IDLE ,0,0,1,0,0)));
        // 24..32: stall and low speed on the same edge -> FAULT
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(ALIGN,1,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 4, mk(ALIGN,0,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(RAMP ,0,0,1,0,0)));
        tbl.push_back(row(1,0,1,199,0,0, 1, mk(RAMP ,0,0,1,0,0)));
        tbl.push_back(row(1,0,1,200,0,0, 1, mk(RUN  ,0,0,0,0,0)));
        tbl.push_back(row(1,0,1,100,0,0, 1, mk(RUN  ,0,0,0,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0,49, mk(RUN  ,0,0,0,0,0)));
        tbl.push_back(row(1,0,1, 50,0,0, 1, mk(FLT  ,0,0,1,1,1)));
        tbl.push_back(row(0,0,0,  0,0,1, 1, mk(IDLE ,0,0,1,0,0)));
        // 33..35: startup again for the reset-in-flight check
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(ALIGN,1,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 4, mk(ALIGN,0,0,1,0,0)));
        tbl.push_back(row(1,0,0,  0,0,0, 1, mk(RAMP ,0,0,1,0,0)));

        r_align_time = 16'd4;  r_ramp_start = 16'd10; r_ramp_min = 16'd4;
        r_ramp_dec   = 16'd3;  r_thr_hi     = 15'd200; r_thr_lo  = 15'd100;
        r_stall_time = 16'd50;
        r_enable = 1'b0; r_brake_in = 1'b0; r_enc_step = 1'b0; r_speed = '0;
        r_speed_valid = 1'b0; r_fault_clear = 1'b0;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        sb.push_back(mk(IDLE,0,0,1,0,0));
        @(posedge clk);
        @(negedge clk);
        sb_check("reset");
        rst = 1'b0;

        run_rows(0, 2);
        for (int i = 0; i < 7; i++)
            wait_pulse(ints[i], vals[i], $sformatf("ramp_pulse%0d", i));
        run_rows(3, 4);
        wait_pulse(10, 3'd2, "ramp_reload");
        run_rows(5, 32);
        run_rows(33, 35);
        wait_pulse(10, 3'd1, "pulse_before_reset");

        // Reset while the pulse is visible: everything back to reset values.
        rst = 1'b1;
        sb.push_back(mk(IDLE,0,0,1,0,0));
        @(posedge clk);
        @(negedge clk);
        sb_check("reset_in_flight");
        rst = 1'b0;
        r_enable = 1'b0;
        sb.push_back(mk(IDLE,0,0,1,0,0));
        @(posedge clk);
        @(negedge clk);
        sb_check("idle_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/motor_commutation_ctrl.md
Name: motor_commutation_ctrl

Overview:
Startup and commutation sequencer for the BLDC drive path. It takes the motor from standstill through rotor alignment and an open-loop forced-commutation ramp. Once measured speed crosses a threshold, it hands over to encoder-driven commutation. It also detects stalls and latches a fault. Its outputs drive the force-step, bypass-power and brake inputs of the pattern generator, and it sits between the speed meter/encoder reader and the output stage.

Parameters:
K_SPDWIDTH, 15, width of speed measurement and speed thresholds
K_TMRWIDTH, 16, width of internal timer and all time/period parameters
K_NSTEPS, 6, commutation steps per electrical revolution (2..8, so step index fits 3 bits)

Ports:
i_clk  in  1  master clock
i_rst  in  1  reset, synchronous, active-high
i_enable  in  1  level run request
i_brake  in  1  level brake request
i_enc_step  in  1  single-cycle encoder step pulse
i_speed  in  K_SPDWIDTH  measured speed
i_speed_valid  in  1  single-cycle qualifier for i_speed
i_fault_clear  in  1  fault acknowledge
i_param_align_time  in  K_TMRWIDTH  cycles spent in ALIGN
i_param_ramp_start  in  K_TMRWIDTH  initial forced-step period (cycles)
i_param_ramp_min  in  K_TMRWIDTH  minimum forced-step period
i_param_ramp_dec  in  K_TMRWIDTH  period decrement per forced step
i_param_spd_thr_hi  in  K_SPDWIDTH  RAMP->RUN speed threshold
i_param_spd_thr_lo  in  K_SPDWIDTH  RUN->RAMP speed threshold (hysteresis, lo <= hi)
i_param_stall_time  in  K_TMRWIDTH  max cycles between encoder steps in RUN; 0 disables
o_force_step_trigger  out  1  single-cycle forced-step pulse
o_force_step_value  out  3  forced step index
o_bypass_power  out  1  1 = output stage ignores power command
o_brake  out  1  brake request to output stage
o_state  out  3  current state encoding
o_fault  out  1  stall fault latched

Behaviour:
- All outputs registered. Reset values: trigger=0, value=0, bypass=1, brake=0, state=IDLE, fault=0. Timer=0, period=0, step index=0.
- State encoding: IDLE=0, ALIGN=1, RAMP=2, RUN=3, BRAKE=4, FAULT=5.
- Global priority per edge: i_rst > FAULT hold > i_brake (any state except FAULT -> BRAKE) > ~i_enable (ALIGN/RAMP/RUN -> IDLE) > state-local rules.
- IDLE: when i_enable=1 and i_brake=0, go to ALIGN. On that edge: step index=0, timer=0, and a trigger pulse with value 0.
- ALIGN: timer increments each cycle. When timer==i_param_align_time, go to RAMP with period=i_param_ramp_start and timer=0. align_time=0 gives one cycle in ALIGN.
- RAMP: timer increments. When timer>=period-1 (period 0 treated as 1):
  - step index=(index+1) mod K_NSTEPS and o_force_step_value=new index, with a one-cycle trigger pulse;
  - timer=0;
  - period=period-dec, clamped to i_param_ramp_min on underflow or when below min.
- RAMP exit: i_speed_valid=1 and i_speed>=thr_hi -> RUN, timer=0. If this coincides with a step-period expiry, the transition wins and no pulse is issued.
- RUN: no forced triggers. Timer clears on i_enc_step, otherwise increments.
  - stall_time!=0 and timer>=stall_time -> FAULT.
  - i_speed_valid=1 and i_speed<thr_lo -> RAMP with period=i_param_ramp_start, timer=0, step index retained.
  - If stall and low speed occur on the same edge, FAULT wins.
- BRAKE: o_brake=1. When i_brake=0, go to IDLE; never straight back to ALIGN.
- FAULT: o_fault=1, o_brake=1, held regardless of i_brake and i_enable. Exit to IDLE only when i_fault_clear=1 and i_enable=0. o_fault clears on that edge.
- o_bypass_power=0 only in RUN. o_brake=1 only in BRAKE and FAULT.
- Outputs change on the same edge as the state register (one-cycle latency from input condition to output).
- Timer saturates at all-ones and never wraps.
- Reset asserted mid-sequence returns everything to reset values on the next edge, including a pulse in flight.

Test Plan:
1. Reset, enable=1, align_time=4 -> trigger value 0 on cycle after enable; ALIGN for 5 cycles; state=RAMP.
2. ramp_start=10, dec=3, min=4 -> forced pulses at intervals 10,7,4,4,...; values 1,2,3,4,5,0,1 with K_NSTEPS=6.
3. In RAMP, valid speed=200 with thr_hi=200 -> RUN next edge, bypass=0. Then speed=99 with thr_lo=100 -> RAMP, bypass=1, period reloads to 10.
4. RUN with stall_time=50, no enc steps -> FAULT at timer=50, fault=1, brake=1. Clear with enable=1 -> stays FAULT. Clear with enable=0 -> IDLE.
5. Brake asserted in RAMP -> BRAKE next edge, brake=1, no triggers. Release with enable=1 -> IDLE then ALIGN.
6. Stall and low speed on the same cycle -> FAULT. Reset during RAMP pulse -> trigger=0, state=IDLE next edge.
